// File: rtl/sound_event_scheduler.sv
// Piezo sound sequencer: latches one-cycle sound requests, arbitrates them by priority
// and plays the selected melody as a square wave, with gaps and preemption.
module sound_event_scheduler #(
  parameter int NOTE_TICKS = 5_000_000,
  parameter int GAP_TICKS  = 500_000,
  parameter int TICK_TICKS = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev_key,
  input  logic       ev_tick,
  input  logic       ev_win,
  input  logic       ev_lose,
  input  logic       ev_clear,
  input  logic       ev_over,
  input  logic       mute,
  output logic       piezo_out,
  output logic       busy,
  output logic [2:0] cur_event,
  output logic [3:0] note_code
);

  localparam int DUR_MAX = (NOTE_TICKS > TICK_TICKS) ? NOTE_TICKS : TICK_TICKS;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);
  localparam int GAP_W   = $clog2(GAP_TICKS + 1);

  localparam logic [2:0] EV_NONE  = 3'd0;
  localparam logic [2:0] EV_KEY   = 3'd1;
  localparam logic [2:0] EV_TICK  = 3'd2;
  localparam logic [2:0] EV_WIN   = 3'd3;
  localparam logic [2:0] EV_LOSE  = 3'd4;
  localparam logic [2:0] EV_CLEAR = 3'd5;
  localparam logic [2:0] EV_OVER  = 3'd6;

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  state_t           state, state_nxt;
  logic [5:0]       pend;
  logic [5:0]       sel_oh;
  logic [5:0]       clr_mask;
  logic [5:0]       ev_vec;
  logic [2:0]       sel_ev;
  logic [2:0]       note_idx;
  logic [16:0]      half_cnt;
  logic [DUR_W-1:0] dur_cnt;
  logic [DUR_W-1:0] dur_m1;
  logic [GAP_W-1:0] gap_cnt;
  logic             tone;
  logic             any_pend;
  logic             preempt;
  logic             tone_end;
  logic             gap_end;
  logic             last_note;

  // Priority class: over 4, clear 3, win/lose 2, tick 1, key 0.
  function automatic logic [2:0] ev_class(input logic [2:0] ev);
    case (ev)
      EV_OVER:         return 3'd4;
      EV_CLEAR:        return 3'd3;
      EV_WIN, EV_LOSE: return 3'd2;
      EV_TICK:         return 3'd1;
      default:         return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] mel_len(input logic [2:0] ev);
    case (ev)
      EV_KEY, EV_TICK: return 3'd1;
      EV_WIN:          return 3'd4;
      EV_LOSE:         return 3'd3;
      EV_CLEAR:        return 3'd6;
      EV_OVER:         return 3'd5;
      default:         return 3'd1;
    endcase
  endfunction

  function automatic logic [3:0] mel_note(input logic [2:0] ev, input logic [2:0] idx);
    logic [3:0] n;
    n = 4'd0;
    case (ev)
      EV_KEY:  n = 4'd11;
      EV_TICK: n = 4'd10;
      EV_WIN:
        case (idx)
          3'd0:    n = 4'd7;
          3'd1:    n = 4'd8;
          3'd2:    n = 4'd9;
          default: n = 4'd11;
        endcase
      EV_LOSE:
        case (idx)
          3'd0:    n = 4'd5;
          3'd1:    n = 4'd3;
          default: n = 4'd1;
        endcase
      EV_CLEAR:
        case (idx)
          3'd0:       n = 4'd7;
          3'd1:       n = 4'd8;
          3'd2, 3'd4: n = 4'd9;
          default:    n = 4'd11;
        endcase
      EV_OVER:
        case (idx)
          3'd0:    n = 4'd5;
          3'd1:    n = 4'd4;
          3'd2:    n = 4'd3;
          3'd3:    n = 4'd2;
          default: n = 4'd1;
        endcase
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  // Half-period in clocks, minus one, so it compares directly with the counter.
  function automatic logic [16:0] half_m1(input logic [3:0] code);
    case (code)
      4'd1:    return 17'd95419;
      4'd2:    return 17'd85033;
      4'd3:    return 17'd75757;
      4'd4:    return 17'd71632;
      4'd5:    return 17'd63775;
      4'd6:    return 17'd50606;
      4'd7:    return 17'd47800;
      4'd8:    return 17'd37935;
      4'd9:    return 17'd31887;
      4'd10:   return 17'd28408;
      4'd11:   return 17'd23877;
      default: return 17'd0;
    endcase
  endfunction

  assign ev_vec = {ev_over, ev_clear, ev_lose, ev_win, ev_tick, ev_key};

  // Lose is checked before win so it takes the tie inside their shared class.
  always_comb begin
    sel_ev = EV_NONE;
    sel_oh = 6'b0;
    if (pend[5])      begin sel_ev = EV_OVER;  sel_oh = 6'b100000; end
    else if (pend[4]) begin sel_ev = EV_CLEAR; sel_oh = 6'b010000; end
    else if (pend[3]) begin sel_ev = EV_LOSE;  sel_oh = 6'b001000; end
    else if (pend[2]) begin sel_ev = EV_WIN;   sel_oh = 6'b000100; end
    else if (pend[1]) begin sel_ev = EV_TICK;  sel_oh = 6'b000010; end
    else if (pend[0]) begin sel_ev = EV_KEY;   sel_oh = 6'b000001; end
  end

  assign any_pend  = |pend;
  assign preempt   = (state != IDLE) && any_pend && (ev_class(sel_ev) > ev_class(cur_event));
  assign dur_m1    = ((cur_event == EV_KEY) || (cur_event == EV_TICK)) ?
                     DUR_W'(TICK_TICKS - 1) : DUR_W'(NOTE_TICKS - 1);
  assign tone_end  = (state == TONE) && (dur_cnt == dur_m1);
  assign gap_end   = (state == GAP) && (gap_cnt == GAP_W'(GAP_TICKS - 1));
  assign last_note = (note_idx == (mel_len(cur_event) - 3'd1));

  // Starting a big melody flushes queued tick/key beeps along with the selected bit.
  always_comb begin
    clr_mask = 6'b0;
    if ((state == IDLE) && any_pend) begin
      clr_mask = sel_oh;
      if (ev_class(sel_ev) >= 3'd2) clr_mask[1:0] = 2'b11;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_pend) state_nxt = TONE;
      TONE: begin
        if (preempt)       state_nxt = IDLE;
        else if (tone_end) state_nxt = GAP;
      end
      GAP: begin
        if (preempt)      state_nxt = IDLE;
        else if (gap_end) state_nxt = last_note ? IDLE : TONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= 6'b0;
      cur_event <= EV_NONE;
      note_code <= 4'd0;
      note_idx  <= 3'd0;
      half_cnt  <= 17'd0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
      tone      <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= (pend & ~clr_mask) | ev_vec;
      case (state)
        IDLE: begin
          if (any_pend) begin
            cur_event <= sel_ev;
            note_idx  <= 3'd0;
            note_code <= mel_note(sel_ev, 3'd0);
            half_cnt  <= 17'd0;
            dur_cnt   <= '0;
            tone      <= 1'b0;
          end
        end
        TONE: begin
          if (preempt) begin
            cur_event <= EV_NONE;
            note_code <= 4'd0;
            tone      <= 1'b0;
          end else if (tone_end) begin
            note_code <= 4'd0;
            tone      <= 1'b0;
            gap_cnt   <= '0;
          end else begin
            dur_cnt <= dur_cnt + DUR_W'(1);
            if (half_cnt == half_m1(note_code)) begin
              half_cnt <= 17'd0;
              tone     <= ~tone;
            end else begin
              half_cnt <= half_cnt + 17'd1;
            end
          end
        end
        GAP: begin
          if (preempt) begin
            cur_event <= EV_NONE;
            note_code <= 4'd0;
          end else if (gap_end) begin
            if (last_note) begin
              cur_event <= EV_NONE;
            end else begin
              note_idx  <= note_idx + 3'd1;
              note_code <= mel_note(cur_event, note_idx + 3'd1);
              half_cnt  <= 17'd0;
              dur_cnt   <= '0;
              tone      <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign piezo_out = (state == TONE) && tone && !mute;

endmodule
